constraint_sweep_driver: RTL

//  Sequential operand sweeper paired with a single-operand combinational constraint cell (x = |f(v)).

---
 rtl/sweep_pkg.sv | 13 +
 rtl/constraint_ref_model.sv | 18 +
 rtl/constraint_sweep_driver.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sweep_pkg.sv
// Shared types and constants for the constraint sweep driver and its reference model.
package sweep_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    // f(v) = (v / REF_DIV) * REF_MUL, truncated to the operand width
    localparam int unsigned REF_DIV = 15;
    localparam int unsigned REF_MUL = 7;

    // A full sweep counts 2**w hits, so the counter needs one extra bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return w + 1;
    endfunction
endpackage

// File: rtl/constraint_ref_model.sv
// Combinational reference for the constraint: x = |(((v / 15) * 7) truncated to W).
module constraint_ref_model
    import sweep_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] v_i,
    output logic         x_o
);
    logic [W-1:0] quot;
    logic [W-1:0] prod;

    always_comb begin
        quot = v_i / W'(REF_DIV);
        prod = quot * W'(REF_MUL);
        x_o  = |prod;
    end
endmodule

// File: rtl/constraint_sweep_driver.sv
// Walks candidates lo..hi through an external constraint cell and tallies its verdicts.
// Optional SWEEP_SELF_CHECK_EN adds a reference model and a mismatch_cnt_o output.
module constraint_sweep_driver
    import sweep_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = cnt_width(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [W-1:0]  lo_i,
    input  logic [W-1:0]  hi_i,
    output logic [W-1:0]  cand_o,
    output logic          cand_vld_o,
    input  logic          sat_i,
    input  logic          sat_vld_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] sat_cnt_o,
    output logic          any_o,
    output logic [W-1:0]  first_o,
    output logic [W-1:0]  last_o
`ifdef SWEEP_SELF_CHECK_EN
    ,
    output logic [CW-1:0] mismatch_cnt_o
`endif
);
    state_e        state_q, state_d;
    logic [W-1:0]  cand_q, cand_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          any_q, any_d;
    logic [W-1:0]  first_q, first_d;
    logic [W-1:0]  last_q, last_d;

`ifdef SWEEP_SELF_CHECK_EN
    logic [CW-1:0] mm_q, mm_d;
    logic          ref_x;

    constraint_ref_model #(.W(W)) u_ref (
        .v_i (cand_q),
        .x_o (ref_x)
    );
`endif

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        any_d   = any_q;
        first_d = first_q;
        last_d  = last_q;
`ifdef SWEEP_SELF_CHECK_EN
        mm_d    = mm_q;
`endif
        // Abort wins over everything, including a same-cycle start; results are kept.
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    cnt_d   = '0;
                    any_d   = 1'b0;
                    first_d = '0;
                    last_d  = '0;
                    hi_d    = hi_i;
                    cand_d  = lo_i;
`ifdef SWEEP_SELF_CHECK_EN
                    mm_d    = '0;
`endif
                    state_d = (lo_i > hi_i) ? DONE : ISSUE;
                end
                ISSUE: state_d = WAIT;
                WAIT: if (sat_vld_i) begin
                    if (sat_i) begin
                        cnt_d  = cnt_q + 1'b1;
                        last_d = cand_q;
                        if (!any_q) first_d = cand_q;
                        any_d  = 1'b1;
                    end
`ifdef SWEEP_SELF_CHECK_EN
                    if (sat_i != ref_x) mm_d = mm_q + 1'b1;
`endif
                    // Stop on equality so hi = all-ones never wraps cand.
                    if (cand_q == hi_q) begin
                        state_d = DONE;
                    end else begin
                        cand_d  = cand_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            any_q   <= 1'b0;
            first_q <= '0;
            last_q  <= '0;
`ifdef SWEEP_SELF_CHECK_EN
            mm_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            any_q   <= any_d;
            first_q <= first_d;
            last_q  <= last_d;
`ifdef SWEEP_SELF_CHECK_EN
            mm_q    <= mm_d;
`endif
        end
    end

    assign cand_o     = cand_q;
    assign cand_vld_o = (state_q == ISSUE);
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign sat_cnt_o  = cnt_q;
    assign any_o      = any_q;
    assign first_o    = first_q;
    assign last_o     = last_q;
`ifdef SWEEP_SELF_CHECK_EN
    assign mismatch_cnt_o = mm_q;
`endif
endmodule
